poly_horner_eval: RTL and testbench



---
 rtl/poly_horner_eval.sv | 125 ++++++++++++
 tb/tb_poly_horner_eval.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/poly_horner_eval.sv
// Serial-load Horner polynomial evaluator: acc = acc*x + a_k, one step per cycle.
// Define POLY_HORNER_SAT_EN to saturate on overflow instead of wrapping modulo 2^WIDTH.
module poly_horner_eval #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEGREE = 3,
  parameter int unsigned IDXW   = $clog2(DEGREE + 2)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  input  logic [WIDTH-1:0] data_in,
  output logic [IDXW-1:0]  load_idx,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  typedef enum logic [2:0] {StLoad, StWait, StInit, StStep, StDone} state_e;

  localparam int unsigned    FullW    = 2 * WIDTH + 1;
  localparam logic [IDXW-1:0] XSlot    = IDXW'(DEGREE + 1);
  localparam logic [IDXW-1:0] LastCoef = IDXW'(DEGREE);

  state_e           state_q;
  logic [WIDTH-1:0] coef_q [DEGREE+1];  // slot order: coef_q[0] = a_N ... coef_q[N] = a_0
  logic [WIDTH-1:0] x_q, acc_q, result_q;
  logic [IDXW-1:0]  idx_q, step_q;
  logic             ovf_int_q, busy_q, done_q, overflow_q;

  logic [FullW-1:0] full;
  logic [WIDTH-1:0] coef_sel, acc_next, res_final;
  logic             step_ovf, ovf_final;

  always_comb begin
    coef_sel = '0;
    for (int unsigned i = 0; i <= DEGREE; i++) begin
      if (step_q == IDXW'(i)) coef_sel = coef_q[i];
    end
    full      = FullW'(acc_q) * FullW'(x_q) + FullW'(coef_sel);
    step_ovf  = |full[FullW-1:WIDTH];
    ovf_final = ovf_int_q | step_ovf;
`ifdef POLY_HORNER_SAT_EN
    acc_next  = step_ovf ? '1 : full[WIDTH-1:0];
    res_final = ovf_final ? '1 : acc_next;
`else
    acc_next  = full[WIDTH-1:0];
    res_final = acc_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StLoad;
      idx_q      <= '0;
      step_q     <= '0;
      x_q        <= '0;
      acc_q      <= '0;
      ovf_int_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i <= DEGREE; i++) coef_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (go) begin
            if (idx_q == XSlot) begin
              x_q <= data_in;
            end else begin
              for (int unsigned i = 0; i <= DEGREE; i++) begin
                if (idx_q == IDXW'(i)) coef_q[i] <= data_in;
              end
            end
            state_q <= StWait;
          end
        end
        StWait: begin
          if (!go) begin
            if (idx_q == XSlot) begin
              busy_q  <= 1'b1;
              state_q <= StInit;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StLoad;
            end
          end
        end
        StInit: begin
          acc_q     <= coef_q[0];
          step_q    <= IDXW'(1);
          ovf_int_q <= 1'b0;
          state_q   <= StStep;
        end
        StStep: begin
          acc_q     <= acc_next;
          ovf_int_q <= ovf_final;
          if (step_q == LastCoef) begin
            result_q   <= res_final;
            overflow_q <= ovf_final;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= StDone;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        StDone: begin
          idx_q   <= '0;
          state_q <= StLoad;
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign load_idx = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_poly_horner_eval.sv
// Self-checking bench for poly_horner_eval: directed/random vector table plus corner sequences.
// Honours POLY_HORNER_SAT_EN the same way the design does.
module tb_poly_horner_eval;

`ifdef POLY_HORNER_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go_a = 1'b0, go_b = 1'b0;
  logic [7:0] din_a = '0, din_b = '0;
  logic [2:0] idx_a;
  logic [1:0] idx_b;
  logic       busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [7:0] res_a, res_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  poly_horner_eval #(.WIDTH(8), .DEGREE(3)) dut_a (
    .clk(clk), .resetn(resetn), .go(go_a), .data_in(din_a), .load_idx(idx_a),
    .busy(busy_a), .done(done_a), .result(res_a), .overflow(ovf_a)
  );

  poly_horner_eval #(.WIDTH(8), .DEGREE(2)) dut_b (
    .clk(clk), .resetn(resetn), .go(go_b), .data_in(din_b), .load_idx(idx_b),
    .busy(busy_b), .done(done_b), .result(res_b), .overflow(ovf_b)
  );

  typedef struct {
    logic [4:0][7:0] c;
    logic [7:0]      x;
    logic [7:0]      res;
    logic            ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0][7:0] mk(input logic [7:0] s0, s1, s2, s3);
    logic [4:0][7:0] r;
    r = '0;
    r[0] = s0; r[1] = s1; r[2] = s2; r[3] = s3;
    return r;
  endfunction

  // Reference: unbounded unsigned Horner, flagging any step that needs more than 8 bits.
  task automatic model(input int n, input logic [4:0][7:0] c, input logic [7:0] x,
                       output logic [7:0] res, output logic ovf);
    longint unsigned acc, f;
    acc = longint'(c[0]);
    ovf = 1'b0;
    for (int s = 1; s <= n; s++) begin
      f = acc * longint'(x) + longint'(c[s]);
      if (f > 255) begin
        ovf = 1'b1;
        acc = Sat ? 255 : (f % 256);
      end else begin
        acc = f;
      end
    end
    res = (Sat && ovf) ? 8'hFF : acc[7:0];
  endtask

  function automatic int cur_idx(input bit b);
    return b ? int'(idx_b) : int'(idx_a);
  endfunction
  function automatic logic cur_busy(input bit b);
    return b ? busy_b : busy_a;
  endfunction
  function automatic logic cur_done(input bit b);
    return b ? done_b : done_a;
  endfunction
  function automatic logic [7:0] cur_res(input bit b);
    return b ? res_b : res_a;
  endfunction
  function automatic logic cur_ovf(input bit b);
    return b ? ovf_b : ovf_a;
  endfunction

  task automatic drive(input bit b, input logic g, input logic [7:0] d);
    if (b) begin go_b = g; din_b = d; end
    else begin go_a = g; din_a = d; end
  endtask

  // Leaves go low just after the capture edge; caller owns the release edge.
  task automatic press(input bit b, input logic [7:0] v);
    drive(b, 1'b1, v);
    @(posedge clk); #1;
    drive(b, 1'b0, v);
  endtask

  task automatic finish_eval(input bit b, input int n, input logic [7:0] er, input logic eo,
                             input string tag);
    logic [7:0] prev;
    int         cyc, busy_cnt;
    bit         held;
    prev = cur_res(b);
    cyc = 0; busy_cnt = 0; held = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (cur_done(b)) begin
        cyc = i;
        break;
      end
      if (cur_busy(b)) busy_cnt++;
      if (cur_res(b) !== prev) held = 1'b0;
    end
    chk({tag, "_latency"}, cyc, n + 2);
    chk({tag, "_busy_cycles"}, busy_cnt, n + 1);
    chk({tag, "_result_held"}, held, 1);
    chk({tag, "_result"}, cur_res(b), er);
    chk({tag, "_overflow"}, cur_ovf(b), eo);
    chk({tag, "_busy_at_done"}, cur_busy(b), 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, cur_done(b), 0);
    chk({tag, "_idx_return"}, cur_idx(b), 0);
  endtask

  task automatic eval(input bit b, input int n, input logic [4:0][7:0] c, input logic [7:0] x,
                      input logic [7:0] er, input logic eo, input string tag);
    for (int s = 0; s <= n; s++) begin
      chk({tag, "_idx"}, cur_idx(b), s);
      press(b, c[s]);
      @(posedge clk); #1;
    end
    chk({tag, "_idx_x"}, cur_idx(b), n + 1);
    press(b, x);
    finish_eval(b, n, er, eo, tag);
  endtask

  initial begin
    vec_t v;
    tbl.push_back('{c: mk(8'd1, 8'd2, 8'd3, 8'd4), x: 8'd2, res: 8'h1A, ovf: 1'b0});
    tbl.push_back('{c: mk(8'd1, 8'd0, 8'd0, 8'd0), x: 8'd7, res: Sat ? 8'hFF : 8'h57, ovf: 1'b1});
    tbl.push_back('{c: mk(8'd0, 8'd0, 8'd0, 8'd0), x: 8'hFF, res: 8'h00, ovf: 1'b0});
    tbl.push_back('{c: mk(8'd0, 8'd0, 8'd0, 8'd5), x: 8'd0, res: 8'h05, ovf: 1'b0});
    tbl.push_back('{c: mk(8'hFF, 8'hFF, 8'hFF, 8'hFF), x: 8'hFF, res: Sat ? 8'hFF : 8'h00,
                    ovf: 1'b1});
    tbl.push_back('{c: mk(8'd0, 8'd0, 8'd1, 8'd0), x: 8'h10, res: 8'h10, ovf: 1'b0});
    tbl.push_back('{c: mk(8'd0, 8'd1, 8'd0, 8'd0), x: 8'h10, res: Sat ? 8'hFF : 8'h00, ovf: 1'b1});
    for (int i = 0; i < 16; i++) begin
      v.c = mk(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      v.x = (i % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      model(3, v.c, v.x, v.res, v.ovf);
      tbl.push_back(v);
    end

    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    chk("rst_idx", idx_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_result", res_a, 0);
    chk("rst_overflow", ovf_a, 0);
    chk("rst_idx_b", idx_b, 0);

    foreach (tbl[i]) eval(1'b0, 3, tbl[i].c, tbl[i].x, tbl[i].res, tbl[i].ovf, $sformatf("v%0d", i));

    // Degree-2 instance: 3*25 + 2*5 + 1.
    eval(1'b1, 2, mk(8'd3, 8'd2, 8'd1, 8'd0), 8'd5, 8'h56, 1'b0, "deg2");

    // Held go: only the first value is captured, index advances only on release.
    drive(1'b0, 1'b1, 8'h11);
    @(posedge clk); #1;
    din_a = 8'h22;
    repeat (19) @(posedge clk);
    #1;
    chk("hold_idx", idx_a, 0);
    go_a = 1'b0;
    @(posedge clk); #1;
    chk("hold_idx_release", idx_a, 1);
    for (int s = 1; s <= 3; s++) begin
      press(1'b0, 8'h00);
      @(posedge clk); #1;
    end
    press(1'b0, 8'h01);
    finish_eval(1'b0, 3, 8'h11, 1'b0, "hold");

    // Reset during the second step cycle discards everything.
    eval(1'b0, 3, mk(8'd1, 8'd2, 8'd3, 8'd4), 8'd2, 8'h1A, 1'b0, "pre_rst");
    for (int s = 0; s <= 3; s++) begin
      press(1'b0, (s == 0) ? 8'd1 : 8'd0);
      @(posedge clk); #1;
    end
    press(1'b0, 8'd7);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_result", res_a, 0);
    chk("midrst_overflow", ovf_a, 0);
    chk("midrst_idx", idx_a, 0);
    eval(1'b0, 3, mk(8'd1, 8'd2, 8'd3, 8'd4), 8'd2, 8'h1A, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
